// File: rtl/kbd_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard sequence controller.
package kbd_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } kbd_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       make;
  } kbd_event_t;

endpackage

// File: rtl/kbd_seq_timer.sv
// Idle-cycle watchdog for partial multi-byte sequences; expired_c fires on the
// idle cycle that would bring the count to TIMEOUT_CYCLES.
module kbd_seq_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  input  logic restart,
  output logic expired_c
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] cnt_q;

  // An accepted byte in the expiry cycle wins over the timeout.
  assign expired_c = run && !restart && (cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (!run || restart || expired_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

endmodule

// File: rtl/kbd_seq_ctrl.sv
// PS/2 scan-code sequence decoder: turns E0/F0-prefixed byte streams into key
// events and tracks the held key. Define KBD_SEQ_REPEAT_FILTER_EN to drop typematic repeats.
module kbd_seq_ctrl
  import kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_make,
  output logic             disp_en,
  output logic [7:0]       disp_code,
  output logic [CNT_W-1:0] press_cnt,
  output logic             proto_err
);

  kbd_state_e state_q, state_d;
  kbd_event_t ev_q, ev_d;
  logic       accept, gen, emit, fault, match, expired_c;
  logic [7:0] held_code;
  logic       held_ext;

  assign in_ready  = !ev_valid || ev_ready;
  assign accept    = in_valid && in_ready;
  assign ev_code   = ev_q.code;
  assign ev_ext    = ev_q.ext;
  assign ev_make   = ev_q.make;

  kbd_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .run      (state_q != IDLE),
    .restart  (accept),
    .expired_c(expired_c)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode, event build and fault detection.
  always_comb begin
    state_d     = state_q;
    gen         = 1'b0;
    fault       = 1'b0;
    ev_d.code   = in_data;
    ev_d.ext    = 1'b0;
    ev_d.make   = 1'b1;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (in_data == SC_BREAK)   state_d = BRK;
          else if (in_data == SC_EXT) state_d = EXT;
          else                        gen = 1'b1;
        end
        EXT: begin
          if (in_data == SC_BREAK) begin
            state_d = EXT_BRK;
          end else if (in_data != SC_EXT) begin
            gen      = 1'b1;
            ev_d.ext = 1'b1;
            state_d  = IDLE;
          end
        end
        BRK, EXT_BRK: begin
          state_d = IDLE;
          if (in_data == SC_BREAK || in_data == SC_EXT) begin
            fault = 1'b1;
          end else begin
            gen       = 1'b1;
            ev_d.ext  = (state_q == EXT_BRK);
            ev_d.make = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (expired_c) begin
      state_d = IDLE;
      fault   = 1'b1;
    end
    match = (ev_d.code == held_code) && (ev_d.ext == held_ext);
`ifdef KBD_SEQ_REPEAT_FILTER_EN
    emit = gen && !(ev_d.make && disp_en && match);
`else
    emit = gen;
`endif
  end

  // Event output register, held-key tracking and press counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ev_q      <= '0;
      ev_valid  <= 1'b0;
      disp_en   <= 1'b0;
      disp_code <= 8'h00;
      held_code <= 8'h00;
      held_ext  <= 1'b0;
      press_cnt <= '0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= fault;
      if (emit) begin
        ev_q     <= ev_d;
        ev_valid <= 1'b1;
      end else if (ev_ready) begin
        ev_valid <= 1'b0;
      end
      if (emit && ev_d.make) begin
        held_code <= ev_d.code;
        held_ext  <= ev_d.ext;
        disp_en   <= 1'b1;
        disp_code <= ev_d.code;
        press_cnt <= press_cnt + CNT_W'(1);
      end else if (emit && match) begin
        disp_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kbd_seq_ctrl.sv
// Self-checking bench for kbd_seq_ctrl against a prefix-flag reference model.
module tb_kbd_seq_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_make;
  logic       disp_en;
  logic [7:0] disp_code;
  logic [7:0] press_cnt;
  logic       proto_err;

  int checks = 0;
  int failures = 0;

  // Reference model: pending prefix flags, idle count, pending event, held key.
  logic       m_ext, m_brk, m_evv, m_ev_ext, m_ev_make, m_disp_en, m_held_ext, m_perr;
  logic [7:0] m_ev_code, m_disp_code, m_held_code;
  int         m_idle, m_cnt;

  always #5 clk = ~clk;

  kbd_seq_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_make(ev_make),
    .disp_en(disp_en), .disp_code(disp_code), .press_cnt(press_cnt),
    .proto_err(proto_err)
  );

  task automatic model_clear();
    m_ext = 0; m_brk = 0; m_evv = 0; m_ev_ext = 0; m_ev_make = 0; m_disp_en = 0;
    m_held_ext = 0; m_perr = 0; m_ev_code = 0; m_disp_code = 0; m_held_code = 0;
    m_idle = 0; m_cnt = 0;
  endtask

  // Drive one cycle of stimulus and advance the model; returns just after the edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic rdy);
    logic acc, emit, e_ext, e_make, perr_n;
    @(negedge clk);
    in_valid = v; in_data = d; ev_ready = rdy;
    acc = v && (!m_evv || rdy);
    emit = 0; e_ext = 0; e_make = 0; perr_n = 0;
    if (acc) begin
      m_idle = 0;
      if (d == 8'hF0 || d == 8'hE0) begin
        if (m_brk) begin perr_n = 1; m_ext = 0; m_brk = 0; end
        else if (d == 8'hF0) m_brk = 1;
        else m_ext = 1;
      end else begin
        emit = 1; e_ext = m_ext; e_make = !m_brk; m_ext = 0; m_brk = 0;
      end
    end else if (m_ext || m_brk) begin
      m_idle++;
      if (m_idle == TO) begin perr_n = 1; m_ext = 0; m_brk = 0; m_idle = 0; end
    end
`ifdef KBD_SEQ_REPEAT_FILTER_EN
    if (emit && e_make && m_disp_en && d == m_held_code && e_ext == m_held_ext) emit = 0;
`endif
    if (emit) begin m_evv = 1; m_ev_code = d; m_ev_ext = e_ext; m_ev_make = e_make; end
    else if (rdy) m_evv = 0;
    if (emit && e_make) begin
      m_held_code = d; m_held_ext = e_ext; m_disp_en = 1; m_disp_code = d; m_cnt++;
    end else if (emit && d == m_held_code && e_ext == m_held_ext) begin
      m_disp_en = 0;
    end
    m_perr = perr_n;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 0; in_valid = 0; ev_ready = 0;
    @(negedge clk);
    resetn = 1;
    model_clear();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL rst_ev_valid got=%b exp=0", ev_valid); end
    checks++; if ({ev_code, ev_ext, ev_make} !== 10'h0) begin failures++; $display("FAIL rst_ev_fields got=%h exp=0", {ev_code, ev_ext, ev_make}); end
    checks++; if ({disp_en, disp_code} !== 9'h0) begin failures++; $display("FAIL rst_disp got=%h exp=0", {disp_en, disp_code}); end
    checks++; if (press_cnt !== 8'h0) begin failures++; $display("FAIL rst_press_cnt got=%h exp=0", press_cnt); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL rst_proto_err got=%b exp=0", proto_err); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    repeat (2) @(negedge clk);
    resetn = 1;
    model_clear();
  endtask

  task automatic test_make_break();
    do_reset();
    cyc(1, 8'h1C, 1);
    checks++; if ({ev_valid, ev_code, ev_ext, ev_make} !== {1'b1, 8'h1C, 1'b0, 1'b1}) begin failures++; $display("FAIL mb_make got=%b_%h_%b%b exp=1_1c_01", ev_valid, ev_code, ev_ext, ev_make); end
    checks++; if (disp_en !== 1'b1) begin failures++; $display("FAIL mb_disp_on got=%b exp=1", disp_en); end
    cyc(1, 8'hF0, 1);
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL mb_prefix_noev got=%b exp=0", ev_valid); end
    cyc(1, 8'h1C, 1);
    checks++; if ({ev_valid, ev_code, ev_ext, ev_make} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin failures++; $display("FAIL mb_break got=%b_%h_%b%b exp=1_1c_00", ev_valid, ev_code, ev_ext, ev_make); end
    checks++; if ({disp_en, disp_code} !== {1'b0, 8'h1C}) begin failures++; $display("FAIL mb_disp_off got=%b_%h exp=0_1c", disp_en, disp_code); end
    checks++; if (press_cnt !== 8'd1) begin failures++; $display("FAIL mb_press_cnt got=%0d exp=1", press_cnt); end
  endtask

  task automatic test_ext();
    do_reset();
    cyc(1, 8'hE0, 1);
    cyc(1, 8'h75, 1);
    checks++; if ({ev_valid, ev_code, ev_ext, ev_make} !== {1'b1, 8'h75, 1'b1, 1'b1}) begin failures++; $display("FAIL ext_make got=%b_%h_%b%b exp=1_75_11", ev_valid, ev_code, ev_ext, ev_make); end
    cyc(1, 8'hE0, 1);
    cyc(1, 8'hF0, 1);
    cyc(1, 8'h75, 1);
    checks++; if ({ev_valid, ev_code, ev_ext, ev_make} !== {1'b1, 8'h75, 1'b1, 1'b0}) begin failures++; $display("FAIL ext_break got=%b_%h_%b%b exp=1_75_10", ev_valid, ev_code, ev_ext, ev_make); end
    checks++; if ({disp_en, disp_code} !== {1'b0, 8'h75}) begin failures++; $display("FAIL ext_disp got=%b_%h exp=0_75", disp_en, disp_code); end
  endtask

  task automatic test_backpressure();
    do_reset();
    cyc(1, 8'h1C, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 8'h32, 0);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
      checks++; if ({ev_valid, ev_code, ev_make} !== {1'b1, 8'h1C, 1'b1}) begin failures++; $display("FAIL bp_hold got=%b_%h_%b exp=1_1c_1", ev_valid, ev_code, ev_make); end
    end
    cyc(1, 8'h32, 1);
    checks++; if ({ev_valid, ev_code} !== {1'b1, 8'h32}) begin failures++; $display("FAIL bp_next got=%b_%h exp=1_32", ev_valid, ev_code); end
    checks++; if (press_cnt !== 8'd2) begin failures++; $display("FAIL bp_press_cnt got=%0d exp=2", press_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    cyc(1, 8'hE0, 1);
    for (int i = 1; i < TO; i++) begin
      cyc(0, 8'h00, 1);
      checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL to_early cycle=%0d got=%b exp=0", i, proto_err); end
    end
    cyc(0, 8'h00, 1);
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL to_pulse got=%b exp=1", proto_err); end
    cyc(0, 8'h00, 1);
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL to_one_cycle got=%b exp=0", proto_err); end
    cyc(1, 8'h1C, 1);
    checks++; if ({ev_valid, ev_code, ev_ext, ev_make} !== {1'b1, 8'h1C, 1'b0, 1'b1}) begin failures++; $display("FAIL to_after got=%b_%h_%b%b exp=1_1c_01", ev_valid, ev_code, ev_ext, ev_make); end
    // Byte arriving exactly on the expiry cycle keeps the sequence alive.
    cyc(1, 8'hE0, 1);
    for (int i = 1; i < TO; i++) cyc(0, 8'h00, 1);
    cyc(1, 8'h75, 1);
    checks++; if ({proto_err, ev_valid, ev_code, ev_ext} !== {1'b0, 1'b1, 8'h75, 1'b1}) begin failures++; $display("FAIL to_precedence got=%b_%b_%h_%b exp=0_1_75_1", proto_err, ev_valid, ev_code, ev_ext); end
  endtask

  task automatic test_repeat();
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 8'h1C, 1);
`ifdef KBD_SEQ_REPEAT_FILTER_EN
    checks++; if (press_cnt !== 8'd1) begin failures++; $display("FAIL rep_press_cnt got=%0d exp=1", press_cnt); end
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL rep_dropped got=%b exp=0", ev_valid); end
`else
    checks++; if (press_cnt !== 8'd3) begin failures++; $display("FAIL rep_press_cnt got=%0d exp=3", press_cnt); end
    checks++; if (ev_valid !== 1'b1) begin failures++; $display("FAIL rep_emitted got=%b exp=1", ev_valid); end
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      cyc(1, 8'(1 + (i % 200)), 1);
      if (i == 254) begin
        checks++; if (press_cnt !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d exp=255", press_cnt); end
      end
    end
    checks++; if (press_cnt !== 8'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", press_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(1, 8'h2A, 0);
    cyc(1, 8'hF0, 1);
    @(negedge clk);
    resetn = 0; in_valid = 0; ev_ready = 0;
    #1;
    checks++; if ({ev_valid, disp_en, press_cnt, disp_code} !== 18'h0) begin failures++; $display("FAIL mid_async got=%h exp=0", {ev_valid, disp_en, press_cnt, disp_code}); end
    @(negedge clk);
    resetn = 1;
    model_clear();
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
    cyc(1, 8'h1C, 1);
    checks++; if ({ev_valid, ev_code, ev_ext, ev_make} !== {1'b1, 8'h1C, 1'b0, 1'b1}) begin failures++; $display("FAIL mid_make got=%b_%h_%b%b exp=1_1c_01", ev_valid, ev_code, ev_ext, ev_make); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic v;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 7))
        0, 1: d = 8'hF0;
        2:    d = 8'hE0;
        3:    d = 8'h1C;
        4:    d = 8'h75;
        default: d = 8'($urandom_range(0, 255));
      endcase
      v = ((i % 100) < 75) ? ($urandom_range(0, 2) != 0) : 1'b0;
      cyc(v, d, 1'($urandom_range(0, 1)));
      checks++; if (ev_valid !== m_evv) begin failures++; $display("FAIL rnd_ev_valid cyc=%0d got=%b exp=%b", i, ev_valid, m_evv); end
      if (m_evv) begin
        checks++; if ({ev_code, ev_ext, ev_make} !== {m_ev_code, m_ev_ext, m_ev_make}) begin failures++; $display("FAIL rnd_ev_fields cyc=%0d got=%h_%b%b exp=%h_%b%b", i, ev_code, ev_ext, ev_make, m_ev_code, m_ev_ext, m_ev_make); end
      end
      checks++; if ({disp_en, disp_code} !== {m_disp_en, m_disp_code}) begin failures++; $display("FAIL rnd_disp cyc=%0d got=%b_%h exp=%b_%h", i, disp_en, disp_code, m_disp_en, m_disp_code); end
      checks++; if (press_cnt !== 8'(m_cnt)) begin failures++; $display("FAIL rnd_press_cnt cyc=%0d got=%0d exp=%0d", i, press_cnt, 8'(m_cnt)); end
      checks++; if (proto_err !== m_perr) begin failures++; $display("FAIL rnd_proto_err cyc=%0d got=%b exp=%b", i, proto_err, m_perr); end
      checks++; if (in_ready !== (!m_evv || ev_ready)) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", i, in_ready, !m_evv || ev_ready); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_make_break();
    test_ext();
    test_backpressure();
    test_timeout();
    test_repeat();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kbd_seq_ctrl.md
KBD_SEQ_CTRL -- requirements
Module: kbd_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, giving the idle cycles allowed inside a multi-byte sequence.
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of the press counter.
REQ-003 SHALL have port clk  in  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  in  1  scan-code byte from the PS/2 receiver is valid.
REQ-006 SHALL have port in_data  in  8  raw scan-code byte.
REQ-007 SHALL have port in_ready  out  1  controller accepts the byte this cycle.
REQ-008 SHALL have port ev_valid  out  1  decoded key event pending.
REQ-009 SHALL have port ev_ready  in  1  consumer takes the event.
REQ-010 SHALL have port ev_code  out  8  key code of the event.
REQ-011 SHALL have port ev_ext  out  1  the event carried the E0 prefix.
REQ-012 SHALL have port ev_make  out  1  1 means press, 0 means release.
REQ-013 SHALL have port disp_en  out  1  digit-enable for the seven-segment drivers; high while a key is held.
REQ-014 SHALL have port disp_code  out  8  code of the currently or last held key.
REQ-015 SHALL have port press_cnt  out  CNT_W  count of accepted make events.
REQ-016 SHALL have port proto_err  out  1  one-cycle pulse on a protocol fault.

Function
REQ-017 SHALL accept a byte when in_valid && in_ready, with in_ready = !ev_valid || ev_ready.
REQ-018 SHALL implement FSM states IDLE, EXT, BRK, EXT_BRK.
REQ-019 SHALL handle IDLE as: F0 -> BRK; E0 -> EXT; any other byte -> make event (ext=0), stay IDLE.
REQ-020 SHALL handle EXT as: F0 -> EXT_BRK; E0 -> stay EXT; any other byte -> make event (ext=1), then IDLE.
REQ-021 SHALL handle BRK as: F0 or E0 -> proto_err pulse, no event, IDLE; any other byte -> break event (ext=0), IDLE.
REQ-022 SHALL handle EXT_BRK as: F0 or E0 -> proto_err pulse, IDLE; any other byte -> break event (ext=1), IDLE.
REQ-023 SHALL register each event so that ev_valid rises the cycle after the byte is accepted, a latency of 1 cycle.
REQ-024 SHALL hold ev_valid and the ev_* fields stable until ev_ready is sampled high.
REQ-025 SHALL, on a make event, set held = {code, ext}, assert disp_en, load disp_code, and increment press_cnt modulo 2^CNT_W (255 wraps to 0).
REQ-026 SHALL, on a break event matching the held {code, ext}, clear disp_en and keep disp_code; a non-matching break changes neither.
REQ-027 SHALL, while in EXT, BRK or EXT_BRK, count idle cycles and, at TIMEOUT_CYCLES, return to IDLE and pulse proto_err.
REQ-028 SHALL restart the timer on every accepted byte; an accepted byte in the same cycle as expiry takes precedence and no proto_err is raised.

Reset
REQ-029 SHALL, with resetn low, immediately force state IDLE, ev_valid=0, ev_code=0, ev_ext=0, ev_make=0, disp_en=0, disp_code=0, press_cnt=0, proto_err=0 and timer=0.
REQ-030 SHALL discard any pending event or partial sequence on a reset asserted mid-operation, so that in_ready=1 on the first cycle after release.

Configuration
REQ-031 SHALL, when macro KBD_SEQ_REPEAT_FILTER_EN is defined, drop a make event whose {code, ext} equals the held key while disp_en=1: no event is emitted and press_cnt does not increment.
REQ-032 SHALL, when KBD_SEQ_REPEAT_FILTER_EN is undefined, emit and count every typematic repeat make.

Structure
REQ-033 SHALL take the state enum, the constants SC_BREAK=8'hF0 and SC_EXT=8'hE0, and the event struct {code, ext, make} from a shared package kbd_pkg.
REQ-034 SHALL implement the timeout counter as sub-module kbd_seq_timer, with its width derived as $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-035 SHALL cover: bytes 1C, F0, 1C with ev_ready=1 -> events {1C, ext0, make1} then {1C, ext0, make0}; press_cnt=1; disp_en 1 then 0.
REQ-036 SHALL cover: bytes E0, 75, E0, F0, 75 -> events {75, ext1, make1} then {75, ext1, make0}; disp_code=75.
REQ-037 SHALL cover: ev_ready=0 while a second byte is offered -> in_ready=0 and the first event stays stable until ev_ready=1.
REQ-038 SHALL cover: E0 followed by silence, with TIMEOUT_CYCLES=16 -> proto_err pulse 16 cycles later, state IDLE; a following 1C gives a make event with ext0.
REQ-039 SHALL cover: 1C repeated 3 times -> press_cnt=1 with the macro defined and 3 without; separately, 256 distinct makes -> press_cnt wraps to 0.
REQ-040 SHALL cover: resetn pulsed low after F0 -> no event; next byte 1C gives a make event.
